// File: rtl/serial_add_ctrl.sv
// One-bit full adder cell; the only arithmetic element in the sequencer.
// Latency: combinational.
// Backpressure: none.
module full_add (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic cout_o
);
    assign sum_o  = a_i ^ b_i ^ c_i;
    assign cout_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// Bit-serial add/subtract sequencer sharing one full_add cell, LSB first.
// Latency: WIDTH cycles from start accept to result_valid.
// Backpressure: result held in DONE until result_ack; start ignored unless ready.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    input  logic             result_ack
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PREV = CNT_W'(WIDTH - 2);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   r_sh_q, r_sh_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c_q, c_d;
    logic               c_msb_q, c_msb_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               fa_sum, fa_cout;

    full_add u_fa (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .c_i    (c_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        c_msb_d  = c_msb_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction runs as A + ~B + 1: invert B, seed carry with 1.
                    a_sh_d  = op_a;
                    b_sh_d  = sub ? ~op_b : op_b;
                    c_d     = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                r_sh_d = {fa_sum, r_sh_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                c_d    = fa_cout;
                cnt_d  = cnt_q + CNT_W'(1);
                // Carry out of bit WIDTH-2 is the carry into the MSB.
                if (cnt_q == CNT_PREV) begin
                    c_msb_d = fa_cout;
                end
                if (cnt_q == CNT_LAST) begin
                    result_d = {fa_sum, r_sh_q[WIDTH-1:1]};
                    carry_d  = fa_cout;
                    ovf_d    = c_msb_q ^ fa_cout;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (result_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            c_msb_q  <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            c_msb_q  <= c_msb_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready        = (state_q == IDLE);
    assign busy         = (state_q == RUN);
    assign result_valid = (state_q == DONE);
    assign result       = result_q;
    assign carry_out    = carry_q;
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench: directed 8-bit vectors plus a back-to-back 16-bit run against a reference model.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- WIDTH=8 instance ----------------
    logic       start8 = 1'b0, sub8 = 1'b0, ack8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       rdy8, busy8, rv8, co8, ov8;
    logic [7:0] res8;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8),
        .op_a(a8), .op_b(b8), .ready(rdy8), .busy(busy8),
        .result_valid(rv8), .result(res8), .carry_out(co8),
        .overflow(ov8), .result_ack(ack8)
    );

    // ---------------- WIDTH=16 instance ----------------
    logic        start16 = 1'b0, sub16 = 1'b0, ack16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic        rdy16, busy16, rv16, co16, ov16;
    logic [15:0] res16;

    serial_add_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16),
        .op_a(a16), .op_b(b16), .ready(rdy16), .busy(busy16),
        .result_valid(rv16), .result(res16), .carry_out(co16),
        .overflow(ov16), .result_ack(ack16)
    );

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        v;
        int          tag;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    // ---------------- monitors ----------------
    exp_t       e8, e16;
    logic       pv8 = 1'b0, pv16 = 1'b0;
    logic [7:0] held8;
    int         last8 = -1, last16 = -1;
    bit         b2b8 = 1'b0;

    always @(negedge clk) begin
        if (rv8 && !pv8) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid8: got result %h with empty scoreboard", res8);
            end else begin
                e8 = q8.pop_front();
                chk("res8", res8, e8.r);
                chk("carry8", co8, e8.c);
                chk("ovf8", ov8, e8.v);
                chk("latency8", cyc - e8.tag, 8);
                if (b2b8 && last8 >= 0) chk("period8", cyc - last8, 10);
                last8 = cyc;
                held8 = res8;
            end
        end else if (rv8 && pv8) begin
            chk("hold8", res8, held8);
        end
        pv8 = rv8;
    end

    always @(negedge clk) begin
        if (rv16 && !pv16) begin
            if (q16.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid16: got result %h with empty scoreboard", res16);
            end else begin
                e16 = q16.pop_front();
                chk("res16", res16, e16.r);
                chk("carry16", co16, e16.c);
                chk("ovf16", ov16, e16.v);
                chk("latency16", cyc - e16.tag, 16);
                if (last16 >= 0) chk("period16", cyc - last16, 18);
                last16 = cyc;
            end
        end
        pv16 = rv16;
    end

    // ---------------- drivers ----------------
    // Call right after a negedge; returns at the negedge following the accepting edge.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [7:0] er, input logic ec, input logic ev, input bit hold);
        int n;
        n = 0;
        while (!rdy8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy8) begin
            total++;
            bad++;
            $display("FAIL ready8_timeout: ready still %b after %0d cycles", rdy8, n);
        end
        a8 = a;
        b8 = b;
        sub8 = s;
        start8 = 1'b1;
        q8.push_back('{r: {8'h00, er}, c: ec, v: ev, tag: cyc + 1});
        @(posedge clk);
        @(negedge clk);
        if (!hold) start8 = 1'b0;
    endtask

    task automatic wait_ready8();
        int n;
        n = 0;
        while (!rdy8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready8_wait", rdy8, 1);
    endtask

    function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b, input logic s, input int tag);
        exp_t e;
        logic [16:0] full;
        full = s ? ({1'b0, a} - {1'b0, b} + 17'h10000) : ({1'b0, a} + {1'b0, b});
        e.r = full[15:0];
        e.c = full[16];
        e.v = s ? ((a[15] != b[15]) && (full[15] != a[15]))
                : ((a[15] == b[15]) && (full[15] != a[15]));
        e.tag = tag;
        return e;
    endfunction

    initial begin
        int n;
        logic [15:0] ra, rb;
        logic rs;

        repeat (3) @(negedge clk);
        chk("rst_ready", rdy8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_valid", rv8, 0);
        chk("rst_result", res8, 8'h00);
        chk("rst_carry", co8, 0);
        chk("rst_ovf", ov8, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add; busy high / ready low for the whole RUN
        ack8 = 1'b1;
        do_op8(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("run_busy", busy8, 1);
            chk("run_ready", rdy8, 0);
            @(negedge clk);
        end
        chk("valid_after_8", rv8, 1);
        wait_ready8();

        // start pulses during RUN and DONE are ignored; result held while ack low
        ack8 = 1'b0;
        do_op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!rv8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("valid_seen", rv8, 1);
        chk("done_ready", rdy8, 0);
        a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_hold_valid", rv8, 1);
        ack8 = 1'b1;
        @(negedge clk);
        chk("ack_ready", rdy8, 1);
        chk("ack_valid", rv8, 0);
        chk("ack_result_kept", res8, 8'h46);

        // Asynchronous abort in the middle of RUN
        do_op8(8'h55, 8'h11, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0);
        void'(q8.pop_back());
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", rdy8, 1);
        chk("abort_busy", busy8, 0);
        chk("abort_valid", rv8, 0);
        chk("abort_result", res8, 8'h00);
        chk("abort_carry", co8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        wait_ready8();

        // Back-to-back with start and ack held high
        last8 = -1;
        b2b8 = 1'b1;
        do_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        do_op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        do_op8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
        do_op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
        do_op8(8'h40, 8'h40, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        do_op8(8'h7F, 8'h80, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
        start8 = 1'b0;
        wait_ready8();
        b2b8 = 1'b0;

        // WIDTH=16 back-to-back, random operands against the model
        for (int i = 0; i < 24; i++) begin
            n = 0;
            while (!rdy16 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!rdy16) begin
                total++;
                bad++;
                $display("FAIL ready16_timeout: ready still %b after %0d cycles", rdy16, n);
            end
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 16'h7FFF; rb = 16'h0001; rs = 1'b0; end
            if (i == 1) begin ra = 16'h8000; rb = 16'h0001; rs = 1'b1; end
            a16 = ra;
            b16 = rb;
            sub16 = rs;
            start16 = 1'b1;
            q16.push_back(model16(ra, rb, rs, cyc + 1));
            @(posedge clk);
            @(negedge clk);
        end
        start16 = 1'b0;

        n = 0;
        while ((q8.size() != 0 || q16.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("q8_drained", q8.size(), 0);
        chk("q16_drained", q16.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
